// File: rtl/ffsr_pkg.sv
// Shared constants for the thermometer-based pulse counter.
// DEPTH is always derived from WIDTH through ffsr_depth().
package ffsr_pkg;

    localparam int FFSR_WIDTH = 3;

    // One thermometer stage per representable non-zero count.
    function automatic int ffsr_depth(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/therm_to_bin.sv
// Combinational thermometer-to-binary converter: the result is the
// population count of the thermometer word.
module therm_to_bin
    import ffsr_pkg::*;
#(
    parameter int WIDTH = FFSR_WIDTH
) (
    input  logic [ffsr_depth(WIDTH)-1:0] therm,
    output logic [WIDTH-1:0]             bin
);

    localparam int DEPTH = ffsr_depth(WIDTH);

    // Counting every bit (rather than locating the top 1) keeps the result
    // meaningful even if the input were ever non-contiguous.
    always_comb begin
        bin = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bin = bin + WIDTH'(therm[i]);
        end
    end

endmodule

// File: rtl/ffsr_pulse_binary.sv
// Saturating up/down pulse counter held as a thermometer shift register,
// with a registered binary readout of the count.
module ffsr_pulse_binary
    import ffsr_pkg::*;
#(
    parameter int WIDTH = FFSR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] out
);

    localparam int DEPTH = ffsr_depth(WIDTH);

    logic [DEPTH-1:0] therm;
    logic [DEPTH-1:0] therm_next;
    logic [WIDTH-1:0] bin_next;

    // Shifting a 1 in at stage 0 or a 0 in at the top keeps the 1s contiguous
    // from stage 0, and both shifts saturate naturally at all-1s / all-0s.
    always_comb begin
        therm_next = therm;
        if (inc && !dec) begin
            therm_next = (therm << 1) | DEPTH'(1);
        end else if (dec && !inc) begin
            therm_next = therm >> 1;
        end
    end

    therm_to_bin #(
        .WIDTH (WIDTH)
    ) u_therm_to_bin (
        .therm (therm_next),
        .bin   (bin_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            therm <= '0;
        end else begin
            therm <= therm_next;
        end
    end

    // Converting the next state keeps out in step with therm (one-cycle
    // latency) while out remains a pure register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= bin_next;
        end
    end

endmodule

// File: tb/tb_ffsr_pulse_binary.sv
// Bench for ffsr_pulse_binary: directed vector table plus randomized
// traffic compared against an integer saturating-counter model.
module tb_ffsr_pulse_binary;

    localparam int W    = 3;
    localparam int D    = (1 << W) - 1;
    localparam int MAXC = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         inc;
    logic         dec;
    logic [W-1:0] out;

    int checks;
    int errors;
    int model_cnt;

    typedef struct {
        logic   rst;
        logic   inc;
        logic   dec;
        int     exp;
    } vec_t;

    vec_t vecs[64];
    int   nvec;

    ffsr_pulse_binary #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .inc (inc),
        .dec (dec),
        .out (out)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add_vec(input logic r, input logic i, input logic d, input int e);
        vecs[nvec].rst = r;
        vecs[nvec].inc = i;
        vecs[nvec].dec = d;
        vecs[nvec].exp = e;
        nvec++;
    endfunction

    function automatic int popcount(input logic [D-1:0] t);
        int n = 0;
        for (int k = 0; k < D; k++) if (t[k]) n++;
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain integer count with clamping.
    task automatic model_step(input logic r, input logic i, input logic d);
        if (r) model_cnt = 0;
        else if (i && !d) model_cnt = (model_cnt + 1 > MAXC) ? MAXC : model_cnt + 1;
        else if (d && !i) model_cnt = (model_cnt - 1 < 0) ? 0 : model_cnt - 1;
    endtask

    // Driver: apply one cycle, then run the per-cycle invariant checks.
    task automatic step(input logic r, input logic i, input logic d);
        logic [D:0] t;
        @(negedge clk);
        rst = r;
        inc = i;
        dec = d;
        @(posedge clk);
        model_step(r, i, d);
        #1;
        t = {1'b0, dut.therm};
        check("therm_contiguous", int'((t & (t + 1)) == 0), 1);
        check("out_vs_popcount", int'(out), popcount(dut.therm));
        check("out_vs_model", int'(out), model_cnt);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_cnt = 0;
        nvec      = 0;
        rst = 1'b0;
        inc = 1'b0;
        dec = 1'b0;

        // reset held for 2 edges, then idle
        add_vec(1, 0, 0, 0);
        add_vec(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) add_vec(0, 0, 0, 0);
        // up-count and saturate at the top
        for (int k = 1; k <= 14; k++) add_vec(0, 1, 0, (k > MAXC) ? MAXC : k);
        // down-count and saturate at zero
        for (int k = 1; k <= 12; k++) add_vec(0, 0, 1, (MAXC - k < 0) ? 0 : MAXC - k);
        // climb to 3, then simultaneous requests cancel
        for (int k = 1; k <= 3; k++) add_vec(0, 1, 0, k);
        for (int k = 0; k < 4; k++) add_vec(0, 1, 1, 3);
        // climb to 5, reset wins over inc, inc resumes
        add_vec(0, 1, 0, 4);
        add_vec(0, 1, 0, 5);
        add_vec(1, 1, 0, 0);
        add_vec(0, 1, 0, 1);

        for (int v = 0; v < nvec; v++) begin
            step(vecs[v].rst, vecs[v].inc, vecs[v].dec);
            check($sformatf("vec%0d", v), int'(out), vecs[v].exp);
        end

        // hand-written corner: reset from saturated top, dec at zero
        for (int k = 0; k < 9; k++) step(0, 1, 0);
        check("sat_top", int'(out), MAXC);
        step(1, 0, 1);
        check("rst_over_dec", int'(out), 0);
        step(0, 0, 1);
        check("dec_at_zero", int'(out), 0);

        // randomized traffic with biased phases to reach both rails
        for (int ph = 0; ph < 12; ph++) begin
            int bias = $urandom_range(0, 2);
            for (int k = 0; k < 40; k++) begin
                logic r, i, d;
                r = ($urandom_range(0, 49) == 0);
                case (bias)
                    0:       begin i = ($urandom_range(0, 3) != 0); d = ($urandom_range(0, 3) == 0); end
                    1:       begin i = ($urandom_range(0, 3) == 0); d = ($urandom_range(0, 3) != 0); end
                    default: begin i = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1)); end
                endcase
                step(r, i, d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ffsr_pulse_binary.md
FFSR_PULSE_BINARY -- requirements
Module: ffsr_pulse_binary

Interface
REQ-001 Parameter: WIDTH, default 3, bit width of the output count; the maximum count is 2^WIDTH-1.
REQ-002 Parameter: DEPTH, default 2^WIDTH-1, number of thermometer stages; it is derived from WIDTH and is not independently overridden.
REQ-003 Port: clk, input, 1, single system clock; all state updates on the rising edge.
REQ-004 Port: rst, input, 1, reset; synchronous and active-high.
REQ-005 Port: inc, input, 1, increment request, sampled each rising edge.
REQ-006 Port: dec, input, 1, decrement request, sampled each rising edge.
REQ-007 Port: out, output, WIDTH, current count, binary-encoded, registered.

Function
REQ-008 The block SHALL be a saturating up/down pulse counter: each clock with a request pulse moves the count by one.
REQ-009 The count SHALL be held internally as a DEPTH-stage thermometer shift register: stage k = 1 iff count > k, and all 1s are contiguous from stage 0.
REQ-010 inc=1, dec=0: SHALL shift a 1 into the thermometer, so the count increases by 1.
REQ-011 dec=1, inc=0: SHALL shift a 0 out from the top of the thermometer, so the count decreases by 1.
REQ-012 inc=0, dec=0: SHALL hold.
REQ-013 inc=1, dec=1 (simultaneous): SHALL hold; the two requests cancel.
REQ-014 Saturation at the top: inc when the count is 2^WIDTH-1 (7 at default) SHALL hold at 2^WIDTH-1; no wrap to 0.
REQ-015 Saturation at the bottom: dec when the count is 0 SHALL hold at 0; no wrap to the maximum.
REQ-016 out SHALL equal the population count of the thermometer, encoded in binary.
REQ-017 out SHALL be driven from registered state, with no combinational path from inc or dec to out.
REQ-018 Latency: a request sampled at edge N SHALL be visible on out after edge N; this is one cycle of latency.
REQ-019 Continuous inc for M cycles from count c SHALL yield out = min(c+M, 2^WIDTH-1).
REQ-020 Continuous dec for M cycles from count c SHALL yield out = max(c-M, 0).
REQ-021 The thermometer SHALL never hold a non-contiguous pattern; the update logic preserves the invariant by construction.

Reset
REQ-022 When rst=1 at a rising edge, all thermometer stages SHALL clear to 0, and out SHALL read 0 after that edge.
REQ-023 Reset SHALL take priority over inc and dec.
REQ-024 Reset asserted mid-count SHALL clear to 0 on the next edge regardless of the prior value.
REQ-025 Before the first reset edge, out is undefined; the bench SHALL NOT check it.

Structure
REQ-026 Shared package ffsr_pkg SHALL hold the default WIDTH constant and a function computing DEPTH = 2^WIDTH-1.
REQ-027 Sub-module therm_to_bin SHALL convert the DEPTH-bit thermometer to a WIDTH-bit binary value; it is purely combinational and parameterised by WIDTH.
REQ-028 The top level SHALL contain:
- the thermometer register,
- the next-state shift logic,
- the output register capturing the therm_to_bin result.

Verification
REQ-029 Reset: hold rst=1 for 2 edges with inc=dec=0, then release -> out=0; idle 3 cycles -> out stays 0.
REQ-030 Up-count and saturate: from 0, hold inc=1 for 14 cycles -> out = 1,2,...,7 on successive edges, then remains 7 for the last 7 cycles.
REQ-031 Down-count and saturate: from 7, hold dec=1 for 12 cycles -> out = 6,5,...,0, then remains 0 for the last 5 cycles.
REQ-032 Simultaneous requests: at count 3, inc=dec=1 for 4 cycles -> out stays 3.
REQ-033 Reset mid-operation: at count 5 with inc=1, assert rst for 1 edge -> out=0 after that edge; the inc continuing next cycle -> out=1.
REQ-034 Invariant check on every cycle:
- the thermometer is contiguous;
- out equals the number of 1s in the thermometer;
- out equals the reference-model count.
